call_button_conditioner: RTL and testbench

Input conditioning stage directly upstream of the call-light controller. Takes the raw, asynchronous call and cancel push-button levels, synchronises and debounces each one, and emits clean single-cycle `call` and `cancel` pulses. These pulses feed the controller's `call` and `cancel` inputs. It also resolves same-cycle press conflicts, so the controller never sees both requests in one cycle.

---
 rtl/call_pkg.sv | 15 +
 rtl/debounce_channel.sv | 93 +++++++++
 rtl/call_button_conditioner.sv | 57 +++++
 tb/tb_call_button_conditioner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/call_pkg.sv
// rtl/call_pkg.sv - shared types and constants for call/cancel button conditioning
package call_pkg;

  // Debounce FSM states; level is high in PRESSED and DISARMING
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    DISARMING = 2'd3
  } db_state_t;

  localparam int SYNC_STAGES             = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchroniser plus debounce FSM for one push button
module debounce_channel
  import call_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  // The entry cycle of ARMING/DISARMING is the first stable sample, so the
  // counter reaching DEBOUNCE_CYCLES-1 after its increment means the sample
  // being taken now completes the stable run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  db_state_t              state;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // Two-flop synchroniser for the asynchronous raw button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // Debounce FSM; counter cleared on every state change and saturating otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        RELEASED: begin
          if (sync) begin
            state <= ARMING;
            cnt   <= '0;
          end
        end
        ARMING: begin
          if (!sync) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            level <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync) begin
            state <= DISARMING;
            cnt   <= '0;
          end
        end
        DISARMING: begin
          if (sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

  // Press strobe for the cycle in which ARMING accepts the press; the top registers it
  assign press = (state == ARMING) && sync && (cnt == CNT_LAST);

endmodule

// File: rtl/call_button_conditioner.sv
// rtl/call_button_conditioner.sv - debounced call/cancel pulses with cancel-wins arbitration
module call_button_conditioner
  import call_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic call_btn,
  input  logic cancel_btn,
  output logic call,
  output logic cancel,
  output logic call_level,
  output logic cancel_level,
  output logic conflict
);

  logic call_press;
  logic cancel_press;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_call_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (call_btn),
    .level(call_level),
    .press(call_press)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_cancel_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (cancel_btn),
    .level(cancel_level),
    .press(cancel_press)
  );

  // Register the pulses; a same-cycle call is dropped in favour of cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      call     <= 1'b0;
      cancel   <= 1'b0;
      conflict <= 1'b0;
    end else begin
      call     <= call_press & ~cancel_press;
      cancel   <= cancel_press;
      conflict <= call_press & cancel_press;
    end
  end

endmodule

// File: tb/tb_call_button_conditioner.sv
// tb/tb_call_button_conditioner.sv - scoreboard bench for call_button_conditioner
module tb_call_button_conditioner;

  localparam int DC  = 4;
  localparam int LAT = DC + 2;

  typedef struct {
    int       cyc;
    logic [2:0] outs;
  } exp_t;

  logic clk;
  logic rst_n;
  logic call_btn;
  logic cancel_btn;
  logic call;
  logic cancel;
  logic call_level;
  logic cancel_level;
  logic conflict;

  int   cyc;
  int   total;
  int   bad;
  int   n;
  exp_t exp_q[$];

  call_button_conditioner #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .call_btn    (call_btn),
    .cancel_btn  (cancel_btn),
    .call        (call),
    .cancel      (cancel),
    .call_level  (call_level),
    .cancel_level(cancel_level),
    .conflict    (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int m);
    repeat (m) @(negedge clk);
  endtask

  // outs packed as {call, cancel, conflict}
  task automatic expect_pulse(input int at, input logic [2:0] outs);
    exp_t e;
    e.cyc  = at;
    e.outs = outs;
    exp_q.push_back(e);
  endtask

  // Monitor: any pulse must match the next scheduled expectation
  always @(negedge clk) begin
    if (call || cancel || conflict) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, call, cancel, conflict}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_outs", {29'd0, call, cancel, conflict}, {29'd0, e.outs});
      end
    end
  end

  initial begin
    cyc        = 0;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    call_btn   = 1'b0;
    cancel_btn = 1'b0;
    step(3);
    check("rst_call", call, 0);
    check("rst_cancel", cancel, 0);
    check("rst_call_level", call_level, 0);
    check("rst_cancel_level", cancel_level, 0);
    check("rst_conflict", conflict, 0);
    rst_n = 1'b1;
    step(2);

    // Clean press, hold 20 cycles, release
    call_btn = 1'b1;
    n = cyc;
    expect_pulse(n + LAT, 3'b100);
    step(LAT - 1);
    check("clean_level_before", call_level, 0);
    step(1);
    check("clean_level_rise", call_level, 1);
    check("clean_no_cancel", cancel, 0);
    step(20 - LAT);
    call_btn = 1'b0;
    step(LAT - 1);
    check("clean_level_hold", call_level, 1);
    step(1);
    check("clean_level_fall", call_level, 0);
    step(6);

    // Bounce 1,0,1,0 every 2 cycles then stay high
    call_btn = 1'b1; step(2);
    call_btn = 1'b0; step(2);
    call_btn = 1'b1; step(2);
    call_btn = 1'b0; step(2);
    call_btn = 1'b1;
    n = cyc;
    expect_pulse(n + LAT, 3'b100);
    step(20);
    check("bounce_level", call_level, 1);
    call_btn = 1'b0;
    step(12);
    check("bounce_level_released", call_level, 0);

    // Short cancel glitch of 3 cycles
    cancel_btn = 1'b1; step(3);
    cancel_btn = 1'b0; step(2);
    check("glitch_level_mid", cancel_level, 0);
    step(10);
    check("glitch_level_end", cancel_level, 0);

    // Simultaneous press: cancel wins, flagged as conflict
    call_btn   = 1'b1;
    cancel_btn = 1'b1;
    n = cyc;
    expect_pulse(n + LAT, 3'b011);
    step(LAT);
    check("simul_cancel_level", cancel_level, 1);
    step(20);
    call_btn   = 1'b0;
    cancel_btn = 1'b0;
    step(12);

    // Hold 30, release 10, press again: two pulses
    call_btn = 1'b1;
    n = cyc;
    expect_pulse(n + LAT, 3'b100);
    step(30);
    call_btn = 1'b0;
    step(LAT - 1);
    check("repress_level_hold", call_level, 1);
    step(1);
    check("repress_level_fall", call_level, 0);
    step(10 - LAT);
    call_btn = 1'b1;
    n = cyc;
    expect_pulse(n + LAT, 3'b100);
    step(15);
    call_btn = 1'b0;
    step(12);

    // Reset two cycles into ARMING with button held
    call_btn = 1'b1;
    step(LAT - 1);
    rst_n = 1'b0;
    step(1);
    check("midrst_call", call, 0);
    check("midrst_call_level", call_level, 0);
    check("midrst_cancel", cancel, 0);
    check("midrst_conflict", conflict, 0);
    step(2);
    rst_n = 1'b1;
    n = cyc;
    expect_pulse(n + LAT, 3'b100);
    step(LAT + 2);
    check("midrst_level_after", call_level, 1);
    call_btn = 1'b0;
    step(12);

    check("pending_expectations", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
